// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - command front-end for the 8-bit registered ALU
// Queues {A,B,Op}, issues one per cycle against result credits, captures tagged results.
module alu_cmd_issue #(
  parameter int CDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_issue,
  input  logic [7:0] alu_r,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_op,
  output logic       res_illegal
);

  localparam int CAW = $clog2(CDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int CRW = $clog2(RDEPTH + 1);

  localparam logic [CAW:0]   CMD_FULL  = (CAW + 1)'(CDEPTH);
  localparam logic [CAW:0]   CMD_ONE   = (CAW + 1)'(1);
  localparam logic [CAW-1:0] CPTR_ONE  = CAW'(1);
  localparam logic [RAW:0]   RES_ONE   = (RAW + 1)'(1);
  localparam logic [RAW-1:0] RPTR_ONE  = RAW'(1);
  localparam logic [CRW-1:0] CRED_INIT = CRW'(RDEPTH);
  localparam logic [CRW-1:0] CRED_ONE  = CRW'(1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef struct packed {
    logic       ill;
    logic [2:0] op;
    logic [7:0] data;
  } res_t;

  // ---------------- command FIFO ----------------
  cmd_t           cmd_mem [CDEPTH];
  logic [CAW-1:0] cmd_wr;
  logic [CAW-1:0] cmd_rd;
  logic [CAW:0]   cmd_cnt;
  logic           cmd_full;
  logic           cmd_empty;
  logic           cmd_push;
  cmd_t           cmd_head;
  logic           head_ill;

  // ---------------- issue / credits ----------------
  logic [CRW-1:0] credits;
  logic           issue;

  // ---------------- tag pipe ----------------
  logic [ALU_LAT:0] tag_v;
  logic [ALU_LAT:0] tag_ill;
  logic [2:0]       tag_op [ALU_LAT+1];
  logic             capture;

  // ---------------- result FIFO ----------------
  res_t           res_mem [RDEPTH];
  logic [RAW-1:0] res_wr;
  logic [RAW-1:0] res_rd;
  logic [RAW:0]   res_cnt;
  logic           res_pop;
  res_t           res_head;

  assign cmd_full  = (cmd_cnt == CMD_FULL);
  assign cmd_empty = (cmd_cnt == '0);
  // Held low through reset so nothing is accepted into a FIFO being cleared.
  assign cmd_ready = !rst && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_head  = cmd_mem[cmd_rd];
  assign head_ill  = (cmd_head.op == 3'd3) || (cmd_head.op == 3'd4) || (cmd_head.op == 3'd5);

  assign issue     = !cmd_empty && (credits != '0);
  assign capture   = tag_v[ALU_LAT];

  assign res_valid = (res_cnt != '0);
  assign res_pop   = res_valid && res_ready;
  assign res_head  = res_mem[res_rd];

  // Head fields are forced to zero when empty so reset and idle look clean.
  assign res_data    = res_valid ? res_head.data : 8'd0;
  assign res_op      = res_valid ? res_head.op   : 3'd0;
  assign res_illegal = res_valid ? res_head.ill  : 1'b0;

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr  <= '0;
      cmd_rd  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) begin
        cmd_wr <= cmd_wr + CPTR_ONE;
      end
      if (issue) begin
        cmd_rd <= cmd_rd + CPTR_ONE;
      end
      if (cmd_push && !issue) begin
        cmd_cnt <= cmd_cnt + CMD_ONE;
      end else if (!cmd_push && issue) begin
        cmd_cnt <= cmd_cnt - CMD_ONE;
      end
    end
  end

  // Operand registers hold their last values when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_op    <= 3'd0;
      alu_issue <= 1'b0;
    end else begin
      alu_issue <= issue;
      if (issue) begin
        alu_a  <= cmd_head.a;
        alu_b  <= cmd_head.b;
        alu_op <= cmd_head.op;
      end
    end
  end

  // One credit per free result slot, so a capture always has room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRED_INIT;
    end else if (issue && !res_pop) begin
      credits <= credits - CRED_ONE;
    end else if (!issue && res_pop) begin
      credits <= credits + CRED_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v   <= '0;
      tag_ill <= '0;
      for (int i = 0; i <= ALU_LAT; i++) begin
        tag_op[i] <= 3'd0;
      end
    end else begin
      tag_v[0]   <= issue;
      tag_ill[0] <= head_ill;
      tag_op[0]  <= cmd_head.op;
      for (int i = 1; i <= ALU_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_ill[i] <= tag_ill[i-1];
        tag_op[i]  <= tag_op[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      res_mem[res_wr] <= '{ill: tag_ill[ALU_LAT], op: tag_op[ALU_LAT], data: alu_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
    end else begin
      if (capture) begin
        res_wr <= res_wr + RPTR_ONE;
      end
      if (res_pop) begin
        res_rd <= res_rd + RPTR_ONE;
      end
      if (capture && !res_pop) begin
        res_cnt <= res_cnt + RES_ONE;
      end else if (!capture && res_pop) begin
        res_cnt <= res_cnt - RES_ONE;
      end
    end
  end

endmodule
